sysarr_mem_driver: RTL and testbench

Memory-side driver for the systolic array's memory interface. It streams N weight rows, then N input rows each paired with its partial-sum row, from a single-read-port scratchpad into the array, honouring `fifo_has_space`. It also captures every output row the array presents and writes it back to the scratchpad. It asserts `done` once all N output rows are written and the array reports `drained`.

---
 rtl/sysarr_mem_driver_pkg.sv | 21 ++
 rtl/sysarr_out_capture.sv | 51 +++++
 rtl/sysarr_mem_driver.sv | 201 ++++++++++++++++++++
 tb/tb_sysarr_mem_driver.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarr_mem_driver_pkg.sv
// rtl/sysarr_mem_driver_pkg.sv - shared FSM state type and sizing helper for the systolic-array memory driver
package sysarr_mem_driver_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_RD,
    ST_W_WAIT,
    ST_W_ISSUE,
    ST_I_RD,
    ST_P_RD,
    ST_P_WAIT,
    ST_ROW_ISSUE,
    ST_DRAIN,
    ST_FIN
  } drv_state_t;

  function automatic int row_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sysarr_out_capture.sv
// rtl/sysarr_out_capture.sv - forwards array output rows to the scratchpad write port and counts them
module sysarr_out_capture
  import sysarr_mem_driver_pkg::*;
#(
  parameter int N      = 4,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10,
  localparam int RW    = row_idx_w(N),
  localparam int OCW   = row_idx_w(N) + 1
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  clear_i,
  input  logic                  active_i,
  input  logic                  out_en_i,
  input  logic [RW-1:0]         row_out_i,
  input  logic [WIDTH*N-1:0]    array_output_i,
  input  logic [ADDR_W-1:0]     o_base_i,
  output logic                  wr_en_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic [WIDTH*N-1:0]    wr_data_o,
  output logic                  count_full_o
);

  logic [OCW-1:0] oc_q;
  logic [OCW-1:0] oc_d;

  // Count saturates at N so late or repeated rows cannot wrap it back below full
  always_comb begin
    oc_d = oc_q;
    if (clear_i) begin
      oc_d = '0;
    end else if (active_i && out_en_i && (oc_q != OCW'(N))) begin
      oc_d = oc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      oc_q <= '0;
    end else begin
      oc_q <= oc_d;
    end
  end

  assign wr_en_o      = active_i & out_en_i;
  assign wr_addr_o    = wr_en_o ? (o_base_i + ADDR_W'(row_out_i)) : '0;
  assign wr_data_o    = wr_en_o ? array_output_i : '0;
  assign count_full_o = (oc_q == OCW'(N));

endmodule

// File: rtl/sysarr_mem_driver.sv
// rtl/sysarr_mem_driver.sv - scratchpad-to-systolic-array row streamer with output write-back; SYSARR_MEM_DRIVER_PERF_EN adds perf counters
module sysarr_mem_driver
  import sysarr_mem_driver_pkg::*;
#(
  parameter int N      = 4,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10,
  localparam int RW    = row_idx_w(N),
  localparam int DW    = WIDTH * N
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              start,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] p_base,
  input  logic [ADDR_W-1:0] o_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              weight_en,
  output logic              input_en,
  output logic              partial_en,
  output logic [RW-1:0]     row_in_en,
  output logic [RW-1:0]     row_ps_en,
  output logic [DW-1:0]     array_in,
  output logic [DW-1:0]     array_in_partials,
  input  logic              fifo_has_space,
  input  logic              out_en,
  input  logic [RW-1:0]     row_out,
  input  logic [DW-1:0]     array_output,
  input  logic              drained
`ifdef SYSARR_MEM_DRIVER_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stalls
`endif
);

  drv_state_t        state_q;
  logic [RW-1:0]     r_q;
  logic [ADDR_W-1:0] w_base_q, i_base_q, p_base_q, o_base_q;
  logic [DW-1:0]     hold_a_q, hold_b_q;
  logic              oc_full;
  logic              start_acc;
  logic              last_row;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign last_row  = (r_q == RW'(N - 1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      w_base_q <= '0;
      i_base_q <= '0;
      p_base_q <= '0;
      o_base_q <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            w_base_q <= w_base;
            i_base_q <= i_base;
            p_base_q <= p_base;
            o_base_q <= o_base;
            r_q      <= '0;
            state_q  <= ST_W_RD;
          end
        end
        ST_W_RD:   state_q <= ST_W_WAIT;
        ST_W_WAIT: begin
          hold_a_q <= rd_data;
          state_q  <= ST_W_ISSUE;
        end
        ST_W_ISSUE: begin
          if (fifo_has_space) begin
            r_q     <= r_q + 1'b1;
            state_q <= last_row ? ST_I_RD : ST_W_RD;
          end
        end
        ST_I_RD: state_q <= ST_P_RD;
        // Input row read in I_RD arrives while the partial read goes out
        ST_P_RD: begin
          hold_a_q <= rd_data;
          state_q  <= ST_P_WAIT;
        end
        ST_P_WAIT: begin
          hold_b_q <= rd_data;
          state_q  <= ST_ROW_ISSUE;
        end
        ST_ROW_ISSUE: begin
          if (fifo_has_space) begin
            r_q     <= r_q + 1'b1;
            state_q <= last_row ? ST_DRAIN : ST_I_RD;
          end
        end
        ST_DRAIN: begin
          if (oc_full && drained) state_q <= ST_FIN;
        end
        ST_FIN:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en             = 1'b0;
    rd_addr           = '0;
    weight_en         = 1'b0;
    input_en          = 1'b0;
    partial_en        = 1'b0;
    row_in_en         = '0;
    row_ps_en         = '0;
    array_in          = '0;
    array_in_partials = '0;
    case (state_q)
      ST_W_RD: begin
        rd_en   = 1'b1;
        rd_addr = w_base_q + ADDR_W'(r_q);
      end
      ST_I_RD: begin
        rd_en   = 1'b1;
        rd_addr = i_base_q + ADDR_W'(r_q);
      end
      ST_P_RD: begin
        rd_en   = 1'b1;
        rd_addr = p_base_q + ADDR_W'(r_q);
      end
      ST_W_ISSUE: begin
        if (fifo_has_space) begin
          weight_en = 1'b1;
          row_in_en = r_q;
          array_in  = hold_a_q;
        end
      end
      ST_ROW_ISSUE: begin
        if (fifo_has_space) begin
          input_en          = 1'b1;
          partial_en        = 1'b1;
          row_in_en         = r_q;
          row_ps_en         = r_q;
          array_in          = hold_a_q;
          array_in_partials = hold_b_q;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done = (state_q == ST_FIN);

  sysarr_out_capture #(
    .N      (N),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_out_capture (
    .clk            (clk),
    .nRST           (nRST),
    .clear_i        (start_acc),
    .active_i       (state_q != ST_IDLE),
    .out_en_i       (out_en),
    .row_out_i      (row_out),
    .array_output_i (array_output),
    .o_base_i       (o_base_q),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .count_full_o   (oc_full)
  );

`ifdef SYSARR_MEM_DRIVER_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (start_acc) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (((state_q == ST_W_ISSUE) || (state_q == ST_ROW_ISSUE)) && !fifo_has_space)
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_sysarr_mem_driver.sv
// tb/tb_sysarr_mem_driver.sv - scoreboard bench for sysarr_mem_driver (scratchpad word k holds k)
`timescale 1ns/1ps
module tb_sysarr_mem_driver;

  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int AW    = 10;
  localparam int DW    = WIDTH * N;
  localparam int RW    = 2;

  logic          clk = 1'b0;
  logic          nRST = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] w_base = '0, i_base = '0, p_base = '0, o_base = '0;
  logic          busy, done, rd_en, wr_en, weight_en, input_en, partial_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] wr_data, array_in, array_in_partials;
  logic [RW-1:0] row_in_en, row_ps_en;
  logic          fifo_has_space = 1'b1;
  logic          out_en = 1'b0;
  logic [RW-1:0] row_out = '0;
  logic [DW-1:0] array_output = '0;
  logic          drained = 1'b0;
`ifdef SYSARR_MEM_DRIVER_PERF_EN
  logic [31:0]   perf_cycles, perf_stalls;
`endif

  always #5 clk = ~clk;

  sysarr_mem_driver #(.N(N), .WIDTH(WIDTH), .ADDR_W(AW)) dut (
    .clk               (clk),
    .nRST              (nRST),
    .start             (start),
    .w_base            (w_base),
    .i_base            (i_base),
    .p_base            (p_base),
    .o_base            (o_base),
    .busy              (busy),
    .done              (done),
    .rd_en             (rd_en),
    .rd_addr           (rd_addr),
    .rd_data           (rd_data),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .weight_en         (weight_en),
    .input_en          (input_en),
    .partial_en        (partial_en),
    .row_in_en         (row_in_en),
    .row_ps_en         (row_ps_en),
    .array_in          (array_in),
    .array_in_partials (array_in_partials),
    .fifo_has_space    (fifo_has_space),
    .out_en            (out_en),
    .row_out           (row_out),
    .array_output      (array_output),
    .drained           (drained)
`ifdef SYSARR_MEM_DRIVER_PERF_EN
    ,
    .perf_cycles       (perf_cycles),
    .perf_stalls       (perf_stalls)
`endif
  );

  typedef struct {
    logic [1:0]    kind;
    logic [RW-1:0] row;
    logic [DW-1:0] a;
    logic [DW-1:0] p;
    int            gap;
  } iss_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  iss_t issue_q[$];
  wr_t  wr_q[$];
  iss_t cur_iss;
  wr_t  cur_wr;

  int checks = 0, errors = 0;
  int cyc = 0, last_iss = 0, inputs_seen = 0, wr_seen = 0, done_cnt = 0, busy_cnt = 0;
  int job_id = 0;

  logic [13:0] outs_vec;
  assign outs_vec = {busy, done, rd_en, wr_en, weight_en, input_en, partial_en,
                     |rd_addr, |wr_addr, |wr_data, |row_in_en, |row_ps_en,
                     |array_in, |array_in_partials};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scratchpad read port: data for a read seen in one cycle appears in the next
  logic          p_en;
  logic [AW-1:0] p_addr;
  initial forever begin
    @(negedge clk);
    p_en   = rd_en;
    p_addr = rd_addr;
    @(posedge clk);
    #1;
    if (p_en) rd_data = DW'(p_addr);
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (weight_en || input_en || partial_en) begin
      chk("issue_space", fifo_has_space, 1);
      if (issue_q.size() == 0) begin
        chk("unexpected_issue", 1, 0);
      end else begin
        cur_iss = issue_q.pop_front();
        chk("issue_kind", {partial_en, input_en, weight_en}, (cur_iss.kind == 2'b01) ? 3'b001 : 3'b110);
        chk("row_in_en", row_in_en, cur_iss.row);
        chk("array_in", array_in, cur_iss.a);
        if (cur_iss.kind == 2'b10) begin
          chk("row_ps_en", row_ps_en, cur_iss.row);
          chk("array_in_partials", array_in_partials, cur_iss.p);
        end
        if (cur_iss.gap != 0) chk("issue_gap", cyc - last_iss, cur_iss.gap);
      end
      last_iss = cyc;
      if (input_en) inputs_seen++;
    end
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        cur_wr = wr_q.pop_front();
        chk("wr_addr", wr_addr, cur_wr.addr);
        chk("wr_data", wr_data, cur_wr.data);
      end
      wr_seen++;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_writes", wr_seen, N);
      chk("done_drained", drained, 1);
    end
  end

  task automatic run_job(input logic [AW-1:0] wb, input logic [AW-1:0] ib, input logic [AW-1:0] pb,
                         input logic [AW-1:0] ob, input bit do_stall, input bit do_restart);
    logic [AW-1:0] a;
    iss_t          e;
    wr_t           w;
    int            t, d0;
    int            order[4];
    order = '{3, 1, 0, 2};
    job_id++;
    for (int r = 0; r < N; r++) begin
      a      = wb + AW'(r);
      e.kind = 2'b01;
      e.row  = RW'(r);
      e.a    = DW'(a);
      e.p    = '0;
      e.gap  = (r == 0) ? 0 : ((do_stall && r == 2) ? 8 : 3);
      issue_q.push_back(e);
    end
    for (int r = 0; r < N; r++) begin
      e.kind = 2'b10;
      e.row  = RW'(r);
      a      = ib + AW'(r);
      e.a    = DW'(a);
      a      = pb + AW'(r);
      e.p    = DW'(a);
      e.gap  = 4;
      issue_q.push_back(e);
    end
    inputs_seen = 0;
    wr_seen     = 0;
    busy_cnt    = 0;
    drained     = 1'b0;
    w_base = wb; i_base = ib; p_base = pb; o_base = ob;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (do_stall) begin
      repeat (8) tick();
      fifo_has_space = 1'b0;
      repeat (5) tick();
      fifo_has_space = 1'b1;
    end
    if (do_restart) begin
      repeat (do_stall ? 7 : 20) tick();
      w_base = ~wb; i_base = ~ib; p_base = ~pb; o_base = ~ob;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    t = 0;
    while (inputs_seen < N && t < 300) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      @(posedge clk);
      #1;
      t++;
    end
    chk("inputs_seen", inputs_seen, N);
    for (int k = 0; k < N; k++) begin
      row_out      = RW'(order[k]);
      array_output = {16'hA5A5, 16'(job_id), 16'h0, 16'(order[k])};
      out_en       = 1'b1;
      w.addr       = ob + AW'(order[k]);
      w.data       = array_output;
      wr_q.push_back(w);
      tick();
    end
    out_en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("drain_busy", busy, 1);
      chk("drain_no_done", done, 0);
      @(posedge clk);
      #1;
    end
    chk("writes_seen", wr_seen, N);
    chk("wr_q_empty", wr_q.size(), 0);
    d0      = done_cnt;
    drained = 1'b1;
    @(negedge clk);
    chk("done_wait", done, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_fin", busy, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("done_count", done_cnt - d0, 1);
    chk("issue_q_empty", issue_q.size(), 0);
`ifdef SYSARR_MEM_DRIVER_PERF_EN
    chk("perf_stalls", perf_stalls, do_stall ? 5 : 0);
    chk("perf_cycles", perf_cycles, busy_cnt);
`endif
    @(posedge clk);
    #1;
    drained = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", outs_vec, 0);
    tick();
    nRST = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_outs", outs_vec, 0);
    tick();

    run_job(10'h000, 10'h010, 10'h020, 10'h030, 1'b0, 1'b0);
    run_job(10'h040, 10'h050, 10'h060, 10'h070, 1'b1, 1'b1);

    // Abort while the first row pair is stalled in ROW_ISSUE
    begin
      iss_t e;
      logic [AW-1:0] a;
      for (int r = 0; r < N; r++) begin
        a      = 10'h100 + AW'(r);
        e.kind = 2'b01;
        e.row  = RW'(r);
        e.a    = DW'(a);
        e.p    = '0;
        e.gap  = (r == 0) ? 0 : 3;
        issue_q.push_back(e);
      end
      w_base = 10'h100; i_base = 10'h110; p_base = 10'h120; o_base = 10'h130;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      fifo_has_space = 1'b0;
      tick();
      @(negedge clk);
      chk("stall_no_issue", input_en, 0);
      chk("stall_busy", busy, 1);
      tick();
`ifdef SYSARR_MEM_DRIVER_PERF_EN
      chk("perf_stalls_pre_rst", perf_stalls, 1);
`endif
      nRST         = 1'b0;
      out_en       = 1'b1;
      row_out      = 2'd1;
      array_output = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      chk("abort_outs", outs_vec, 0);
`ifdef SYSARR_MEM_DRIVER_PERF_EN
      chk("abort_perf", {perf_cycles, perf_stalls}, 0);
`endif
      tick();
      nRST = 1'b1;
      @(negedge clk);
      chk("idle_ignore_out_en", wr_en, 0);
      chk("post_abort_outs", outs_vec, 0);
      tick();
      out_en         = 1'b0;
      fifo_has_space = 1'b1;
      chk("abort_issue_q_empty", issue_q.size(), 0);
      tick();
    end

    run_job(10'h3FE, 10'h3FC, 10'h3FF, 10'h3FE, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
